// File: rtl/noc_link_pkg.sv
// Shared types, defaults and helpers for the credit-based inter-router link stage.
package noc_link_pkg;

  localparam int DEFAULT_FLIT_WIDTH = 128;
  localparam int DEFAULT_DEST_WIDTH = 6;

  // Packet framing as seen by the monitor at the upstream boundary.
  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } link_state_e;

  // Bits needed to hold a credit count from 0 up to and including depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_pipe_stage.sv
// One link register stage: a resettable valid bit plus a payload that is
// never reset, so a chain of these can map onto shift-register primitives.
// WIDTH=0 gives a valid-only stage whose payload port is a plain wire.
module noc_pipe_stage #(
  parameter int   WIDTH       = 1,
  parameter logic RESET_VALID = 1'b0,
  localparam int  PW          = (WIDTH > 0) ? WIDTH : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [PW-1:0] payload_in,
  output logic          valid_out,
  output logic [PW-1:0] payload_out
);

  // Valid bit: cleared by reset so in-flight flits/credits are discarded.
  // NOTE: sequential state is written with <= so every stage samples the
  // previous stage's old value on the same edge; = here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_out <= RESET_VALID;
    else        valid_out <= valid_in;
  end

  if (WIDTH > 0) begin : g_payload
    // Payload capture, unconditionally every cycle; meaningless while valid_out=0.
    // NOTE: no reset on the payload on purpose -- a reset would prevent SRL
    // mapping, and the valid bit already marks the contents as garbage.
    always_ff @(posedge clk) begin
      payload_out <= payload_in;
    end
  end else begin : g_no_payload
    assign payload_out = payload_in;
  end

endmodule

// File: rtl/noc_pipeline_link.sv
// Credit-based link stage between two routers: NUM_PIPELINE register stages
// on the flit path and on the credit return path, plus a protocol monitor at
// the upstream boundary (credit count, framing, sticky errors, statistics).
module noc_pipeline_link
  import noc_link_pkg::*;
#(
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_WIDTH        = DEFAULT_FLIT_WIDTH,
  parameter int DEST_WIDTH        = DEFAULT_DEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [FLIT_WIDTH-1:0]                       data_in,
  input  logic [DEST_WIDTH-1:0]                       dest_in,
  input  logic                                        is_tail_in,
  input  logic                                        send_in,
  output logic                                        credit_out,
  output logic [FLIT_WIDTH-1:0]                       data_out,
  output logic [DEST_WIDTH-1:0]                       dest_out,
  output logic                                        is_tail_out,
  output logic                                        send_out,
  input  logic                                        credit_in,
  output logic [credit_width(FLIT_BUFFER_DEPTH)-1:0]  credits_avail,
  output logic                                        err_send_no_credit,
  output logic                                        err_credit_overflow,
  output logic                                        err_dest_change,
  output logic [CNT_WIDTH-1:0]                        flit_count,
  output logic [CNT_WIDTH-1:0]                        pkt_count
);

  localparam int                PW       = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int                CRED_W   = credit_width(FLIT_BUFFER_DEPTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FLIT_BUFFER_DEPTH);

  // ---------------------------------------------------------------------------
  // Pipeline chains; index 0 is the input side, NUM_PIPELINE the output side.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] fwd_payload        [NUM_PIPELINE+1];
  logic          fwd_valid          [NUM_PIPELINE+1];
  logic          crd_valid          [NUM_PIPELINE+1];
  logic          crd_payload_unused [NUM_PIPELINE+1];

  assign fwd_payload[0]        = {is_tail_in, dest_in, data_in};
  assign fwd_valid[0]          = send_in;
  assign crd_valid[0]          = credit_in;
  assign crd_payload_unused[0] = 1'b0;

  for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_stage
    noc_pipe_stage #(.WIDTH(PW), .RESET_VALID(1'b0)) u_fwd (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (fwd_valid[i]),
      .payload_in  (fwd_payload[i]),
      .valid_out   (fwd_valid[i+1]),
      .payload_out (fwd_payload[i+1])
    );

    noc_pipe_stage #(.WIDTH(0), .RESET_VALID(1'b0)) u_crd (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (crd_valid[i]),
      .payload_in  (crd_payload_unused[i]),
      .valid_out   (crd_valid[i+1]),
      .payload_out (crd_payload_unused[i+1])
    );
  end

  assign {is_tail_out, dest_out, data_out} = fwd_payload[NUM_PIPELINE];
  assign send_out   = fwd_valid[NUM_PIPELINE];
  assign credit_out = crd_valid[NUM_PIPELINE];

  // ---------------------------------------------------------------------------
  // Sender credit count, tracked with send_in and the delayed credit_out.
  // ---------------------------------------------------------------------------
  logic [CRED_W-1:0] credits_next;
  logic              no_credit_hit;
  logic              overflow_hit;

  // Credit update: saturate at both ends and flag the protocol violation instead.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    credits_next  = credits_avail;
    no_credit_hit = 1'b0;
    overflow_hit  = 1'b0;
    if (send_in && !credit_out) begin
      if (credits_avail == '0) no_credit_hit = 1'b1;
      else                     credits_next  = credits_avail - 1'b1;
    end else if (credit_out && !send_in) begin
      if (credits_avail == CRED_MAX) overflow_hit = 1'b1;
      else                           credits_next = credits_avail + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet framing monitor.
  // ---------------------------------------------------------------------------
  link_state_e           state, state_next;
  logic [DEST_WIDTH-1:0] dest_latched;
  logic                  latch_dest;
  logic                  pkt_done;
  logic                  dest_mismatch;

  // Framing next-state: a head flit opens a packet, its tail closes it.
  always_comb begin
    state_next    = state;
    latch_dest    = 1'b0;
    pkt_done      = 1'b0;
    dest_mismatch = 1'b0;
    if (send_in) begin
      unique case (state)
        IDLE: begin
          if (is_tail_in) begin
            pkt_done = 1'b1;
          end else begin
            state_next = BODY;
            latch_dest = 1'b1;
          end
        end
        BODY: begin
          dest_mismatch = (dest_in != dest_latched);
          if (is_tail_in) begin
            pkt_done   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Framing state and the head-flit destination used for mid-packet compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dest_latched <= '0;
    end else begin
      state <= state_next;
      if (latch_dest) dest_latched <= dest_in;
    end
  end

  // Credit count, sticky error flags and saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_avail       <= CRED_MAX;
      err_send_no_credit  <= 1'b0;
      err_credit_overflow <= 1'b0;
      err_dest_change     <= 1'b0;
      flit_count          <= '0;
      pkt_count           <= '0;
    end else begin
      credits_avail <= credits_next;
      if (no_credit_hit) err_send_no_credit  <= 1'b1;
      if (overflow_hit)  err_credit_overflow <= 1'b1;
      if (dest_mismatch) err_dest_change     <= 1'b1;
      if (send_in && (flit_count != '1)) flit_count <= flit_count + CNT_WIDTH'(1);
      if (pkt_done && (pkt_count != '1))  pkt_count  <= pkt_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_noc_pipeline_link.sv
// Directed bench: a 2-stage link (depth 4) and a 0-stage link with 4-bit counters.
// Inputs are driven at the falling edge; registered outputs are observed at
// the falling edge before the new inputs are applied.
module tb_noc_pipeline_link;
  import noc_link_pkg::*;

  localparam int FW    = 128;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int CRW   = credit_width(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Two-stage link under test.
  logic [FW-1:0]  data_in, data_out;
  logic [DW-1:0]  dest_in, dest_out;
  logic           is_tail_in, is_tail_out, send_in, send_out, credit_in, credit_out;
  logic [CRW-1:0] credits_avail;
  logic           err_send_no_credit, err_credit_overflow, err_dest_change;
  logic [31:0]    flit_count, pkt_count;

  // Pass-through link with narrow counters.
  logic [FW-1:0]  p0_data_in, p0_data_out;
  logic [DW-1:0]  p0_dest_in, p0_dest_out;
  logic           p0_is_tail_in, p0_is_tail_out, p0_send_in, p0_send_out;
  logic           p0_credit_in, p0_credit_out;
  logic [CRW-1:0] p0_credits_avail;
  logic           p0_err_send_no_credit, p0_err_credit_overflow, p0_err_dest_change;
  logic [3:0]     p0_flit_count, p0_pkt_count;

  int vectors     = 0;
  int miscompares = 0;

  noc_pipeline_link #(
    .NUM_PIPELINE(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .credits_avail(credits_avail),
    .err_send_no_credit(err_send_no_credit), .err_credit_overflow(err_credit_overflow),
    .err_dest_change(err_dest_change), .flit_count(flit_count), .pkt_count(pkt_count)
  );

  noc_pipeline_link #(
    .NUM_PIPELINE(0), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(DEPTH), .CNT_WIDTH(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .data_in(p0_data_in), .dest_in(p0_dest_in), .is_tail_in(p0_is_tail_in), .send_in(p0_send_in),
    .credit_out(p0_credit_out),
    .data_out(p0_data_out), .dest_out(p0_dest_out), .is_tail_out(p0_is_tail_out),
    .send_out(p0_send_out),
    .credit_in(p0_credit_in), .credits_avail(p0_credits_avail),
    .err_send_no_credit(p0_err_send_no_credit), .err_credit_overflow(p0_err_credit_overflow),
    .err_dest_change(p0_err_dest_change), .flit_count(p0_flit_count), .pkt_count(p0_pkt_count)
  );

  task automatic drive(input logic send, input logic tail, input logic [DW-1:0] dest,
                       input logic [FW-1:0] data, input logic credit);
    send_in    = send;
    is_tail_in = tail;
    dest_in    = dest;
    data_in    = data;
    credit_in  = credit;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL rst_send_out: got %b expected 0", send_out); end
    vectors++; if (credit_out !== 1'b0) begin miscompares++; $display("FAIL rst_credit_out: got %b expected 0", credit_out); end
    vectors++; if (credits_avail !== CRW'(DEPTH)) begin miscompares++; $display("FAIL rst_credits: got %0d expected %0d", credits_avail, DEPTH); end
    vectors++; if ({err_send_no_credit, err_credit_overflow, err_dest_change} !== 3'b000) begin
      miscompares++; $display("FAIL rst_errors: got %b expected 000", {err_send_no_credit, err_credit_overflow, err_dest_change}); end
    vectors++; if (flit_count !== 32'd0 || pkt_count !== 32'd0) begin
      miscompares++; $display("FAIL rst_counters: got flit=%0d pkt=%0d expected 0/0", flit_count, pkt_count); end
  endtask

  // Four single-flit packets back to back; they must emerge two cycles later.
  task automatic test_forward();
    logic [FW-1:0] d [4];
    logic          exp_send;
    for (int i = 0; i < 4; i++) d[i] = {4{32'hA500_0000 + 32'(i)}};
    for (int n = 0; n < 8; n++) begin
      exp_send = (n >= 2) && (n <= 5);
      vectors++; if (send_out !== exp_send) begin miscompares++; $display("FAIL fwd_send n=%0d: got %b expected %b", n, send_out, exp_send); end
      if (exp_send) begin
        vectors++; if (dest_out !== 6'h05) begin miscompares++; $display("FAIL fwd_dest n=%0d: got %h expected 05", n, dest_out); end
        vectors++; if (data_out !== d[n-2]) begin miscompares++; $display("FAIL fwd_data n=%0d: got %h expected %h", n, data_out, d[n-2]); end
        vectors++; if (is_tail_out !== 1'b1) begin miscompares++; $display("FAIL fwd_tail n=%0d: got %b expected 1", n, is_tail_out); end
      end
      if (n == 4) begin
        vectors++; if (credits_avail !== CRW'(0)) begin miscompares++; $display("FAIL fwd_credits n=4: got %0d expected 0", credits_avail); end
      end
      if (n < 4) drive(1'b1, 1'b1, 6'h05, d[n], 1'b0);
      else       idle();
      @(negedge clk);
    end
    vectors++; if (pkt_count !== 32'd4) begin miscompares++; $display("FAIL fwd_pkt_count: got %0d expected 4", pkt_count); end
    vectors++; if (flit_count !== 32'd4) begin miscompares++; $display("FAIL fwd_flit_count: got %0d expected 4", flit_count); end
    vectors++; if ({err_send_no_credit, err_credit_overflow, err_dest_change} !== 3'b000) begin
      miscompares++; $display("FAIL fwd_errors: got %b expected 000", {err_send_no_credit, err_credit_overflow, err_dest_change}); end
  endtask

  // Four consecutive credit pulses: each one delayed by two and counted back.
  task automatic test_credit_return();
    logic           exp_co;
    logic [CRW-1:0] exp_cr;
    for (int n = 0; n < 8; n++) begin
      exp_co = (n >= 2) && (n <= 5);
      exp_cr = (n <= 2) ? CRW'(0) : ((n >= 6) ? CRW'(4) : CRW'(n - 2));
      vectors++; if (credit_out !== exp_co) begin miscompares++; $display("FAIL crd_out n=%0d: got %b expected %b", n, credit_out, exp_co); end
      vectors++; if (credits_avail !== exp_cr) begin miscompares++; $display("FAIL crd_count n=%0d: got %0d expected %0d", n, credits_avail, exp_cr); end
      drive(1'b0, 1'b0, '0, '0, n < 4);
      @(negedge clk);
    end
    vectors++; if (err_credit_overflow !== 1'b0) begin miscompares++; $display("FAIL crd_overflow: got %b expected 0", err_credit_overflow); end
  endtask

  // Fifth send with no credit, then a credit beyond the buffer depth.
  task automatic test_credit_errors();
    for (int n = 0; n < 6; n++) begin
      if (n == 4) begin
        vectors++; if (err_send_no_credit !== 1'b0) begin miscompares++; $display("FAIL nocrd_before: got %b expected 0", err_send_no_credit); end
        vectors++; if (credits_avail !== CRW'(0)) begin miscompares++; $display("FAIL nocrd_count4: got %0d expected 0", credits_avail); end
      end
      if (n == 5) begin
        vectors++; if (err_send_no_credit !== 1'b1) begin miscompares++; $display("FAIL nocrd_flag: got %b expected 1", err_send_no_credit); end
        vectors++; if (credits_avail !== CRW'(0)) begin miscompares++; $display("FAIL nocrd_hold: got %0d expected 0", credits_avail); end
      end
      if (n < 5) drive(1'b1, 1'b1, 6'h01, '0, 1'b0);
      else       idle();
      @(negedge clk);
    end
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    vectors++; if (credits_avail !== CRW'(4) || err_credit_overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_refill: got credits=%0d ovf=%b expected 4/0", credits_avail, err_credit_overflow); end
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    vectors++; if (err_credit_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", err_credit_overflow); end
    vectors++; if (credits_avail !== CRW'(4)) begin miscompares++; $display("FAIL ovf_hold: got %0d expected 4", credits_avail); end
  endtask

  // Three-flit packet whose body flit carries a different destination.
  task automatic test_dest_change();
    apply_reset();
    drive(1'b1, 1'b0, 6'h0A, '0, 1'b0);
    @(negedge clk);
    vectors++; if (err_dest_change !== 1'b0) begin miscompares++; $display("FAIL dest_head: got %b expected 0", err_dest_change); end
    drive(1'b1, 1'b0, 6'h0B, '0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 6'h0A, '0, 1'b0);
    @(negedge clk);
    idle();
    vectors++; if (err_dest_change !== 1'b1) begin miscompares++; $display("FAIL dest_flag: got %b expected 1", err_dest_change); end
    vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL dest_pkt_count: got %0d expected 1", pkt_count); end
    vectors++; if (flit_count !== 32'd3) begin miscompares++; $display("FAIL dest_flit_count: got %0d expected 3", flit_count); end
  endtask

  // send_in coinciding with credit_out must leave the count unchanged.
  task automatic test_same_cycle();
    apply_reset();
    drive(1'b1, 1'b1, 6'h03, '0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 6'h03, '0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    idle();
    @(negedge clk);
    vectors++; if (credit_out !== 1'b1) begin miscompares++; $display("FAIL same_credit_out: got %b expected 1", credit_out); end
    vectors++; if (credits_avail !== CRW'(2)) begin miscompares++; $display("FAIL same_before: got %0d expected 2", credits_avail); end
    drive(1'b1, 1'b1, 6'h03, '0, 1'b0);
    @(negedge clk);
    idle();
    vectors++; if (credits_avail !== CRW'(2)) begin miscompares++; $display("FAIL same_after: got %0d expected 2", credits_avail); end
  endtask

  // Reset with a head and body flit in flight; the pipe and monitor must clear.
  task automatic test_reset_mid_packet();
    drive(1'b1, 1'b0, 6'h11, '1, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 6'h11, '1, 1'b0);
    @(negedge clk);
    idle();
    vectors++; if (send_out !== 1'b1) begin miscompares++; $display("FAIL midrst_inflight: got %b expected 1", send_out); end
    rst_n = 1'b0;
    #1;
    vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL midrst_send_out: got %b expected 0", send_out); end
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (credits_avail !== CRW'(4)) begin miscompares++; $display("FAIL midrst_credits: got %0d expected 4", credits_avail); end
    drive(1'b1, 1'b1, 6'h22, '0, 1'b0);
    @(negedge clk);
    idle();
    vectors++; if (send_out !== 1'b0) begin miscompares++; $display("FAIL midrst_flushed: got %b expected 0", send_out); end
    vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL midrst_idle_pkt: got %0d expected 1", pkt_count); end
    vectors++; if (err_dest_change !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_dest: got %b expected 0", err_dest_change); end
  endtask

  // Zero-stage link: same-cycle wires, and 4-bit counters that saturate.
  task automatic test_passthrough();
    logic [FW-1:0] pat;
    pat = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      p0_send_in    = 1'b1;
      p0_is_tail_in = 1'b1;
      p0_dest_in    = 6'h2A;
      p0_data_in    = pat ^ FW'(i);
      p0_credit_in  = 1'b1;
      if (i == 0) begin
        #1;
        vectors++; if (p0_send_out !== 1'b1 || p0_credit_out !== 1'b1) begin
          miscompares++; $display("FAIL p0_wires: got send=%b credit=%b expected 1/1", p0_send_out, p0_credit_out); end
        vectors++; if (p0_data_out !== pat || p0_dest_out !== 6'h2A || p0_is_tail_out !== 1'b1) begin
          miscompares++; $display("FAIL p0_fields: got data=%h dest=%h tail=%b expected %h/2a/1", p0_data_out, p0_dest_out, p0_is_tail_out, pat); end
      end
      if (i == 14) begin
        vectors++; if (p0_flit_count !== 4'hE) begin miscompares++; $display("FAIL p0_count14: got %h expected e", p0_flit_count); end
      end
      if (i == 15) begin
        vectors++; if (p0_flit_count !== 4'hF) begin miscompares++; $display("FAIL p0_count15: got %h expected f", p0_flit_count); end
      end
    end
    @(negedge clk);
    p0_send_in   = 1'b0;
    p0_credit_in = 1'b0;
    #1;
    vectors++; if (p0_send_out !== 1'b0 || p0_credit_out !== 1'b0) begin
      miscompares++; $display("FAIL p0_idle: got send=%b credit=%b expected 0/0", p0_send_out, p0_credit_out); end
    vectors++; if (p0_flit_count !== 4'hF || p0_pkt_count !== 4'hF) begin
      miscompares++; $display("FAIL p0_saturate: got flit=%h pkt=%h expected f/f", p0_flit_count, p0_pkt_count); end
    vectors++; if (p0_credits_avail !== CRW'(4) || {p0_err_send_no_credit, p0_err_credit_overflow, p0_err_dest_change} !== 3'b000) begin
      miscompares++; $display("FAIL p0_monitor: got credits=%0d errs=%b expected 4/000", p0_credits_avail,
                              {p0_err_send_no_credit, p0_err_credit_overflow, p0_err_dest_change}); end
  endtask

  initial begin
    idle();
    p0_send_in    = 1'b0;
    p0_is_tail_in = 1'b0;
    p0_dest_in    = '0;
    p0_data_in    = '0;
    p0_credit_in  = 1'b0;
    test_reset();
    test_forward();
    test_credit_return();
    test_credit_errors();
    test_dest_change();
    test_same_cycle();
    test_reset_mid_packet();
    test_passthrough();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
